fact_ctrl: RTL and testbench
============================

// Module: fact_ctrl
// PURPOSE
//  Control unit for the factorial datapath (counter / comparator / multiplier / result register).
//  Accepts a request (n), sequences the datapath strobes until comp reports n<cuenta,
//  then presents n! on a valid/ready result port held until consumed.
//  Sits directly beside the datapath: drives its n/inic/habilita_c/fuente/cargar, reads comp/salida.
// PARAMETERS
//  N_W    3   width of operand n (max n = 2**N_W-1)
//  RES_W  13  width of result; 13 holds 7! = 5040
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      reset, synchronous, active-high
//  start      in   1      request pulse/level; sampled only in IDLE
//  n_in       in   N_W    operand, captured when start accepted
//  comp       in   1      datapath comparator (n < cuenta)
//  salida     in   RES_W  datapath result register
//  n          out  N_W    latched operand to datapath
//  inic       out  1      datapath: load cuenta=1 (with habilita_c)
//  habilita_c out  1      datapath: counter enable
//  fuente     out  1      datapath: mux select, 1 -> constant 1, 0 -> product
//  cargar     out  1      datapath: result register load
//  busy       out  1      high whenever state != IDLE
//  res_valid  out  1      result available
//  res_data   out  RES_W  captured n!
//  res_ready  in   1      consumer accepts result
//  res_err    out  1      watchdog abort flag (qualified by res_valid)
// BEHAVIOUR
//  Reset: state=IDLE; n, res_data = 0; res_valid, res_err = 0; all strobes 0; busy 0. Reset mid-operation aborts, no result.
//  FSM (registered state, strobes decoded combinationally from state and comp):
//   IDLE : strobes 0. start=1 -> capture n<=n_in, go INIT. start outside IDLE is ignored (not queued).
//   INIT : habilita_c=1 inic=1 fuente=1 cargar=1 (cuenta<=1, salida<=1). -> LOOP.
//   LOOP : comp=0 -> habilita_c=1 inic=0 fuente=0 cargar=1 (salida<=cuenta*salida, cuenta++), stay.
//          comp=1 -> strobes 0, res_data<=salida, res_valid<=1, -> DONE.
//   DONE : strobes 0; res_valid, res_data, res_err held stable until res_ready=1, then -> IDLE
//          and res_valid=0 the next cycle. res_ready while !res_valid has no effect.
//  Latency: start high in cycle T (IDLE) -> INIT in T+1, LOOP T+2..T+2+n, res_valid first high in T+n+3.
//  n=0: one LOOP cycle (cuenta=1 > 0), result 1. n=7: result 5040. No overflow within defaults.
//  New request: earliest accepted in the cycle after the DONE handshake (IDLE).
//  n is held constant from INIT through DONE; n_in changes while busy are ignored.
// CONFIGURATION
//  FACT_WDOG_EN defined: iteration counter (N_W+1 bits) cleared in INIT, +1 per LOOP cycle with comp=0.
//   Reaching 2**N_W while still comp=0 -> abort to DONE with res_data=0, res_err=1.
//   res_err cleared at DONE handshake and on reset.
//  FACT_WDOG_EN undefined: no counter; res_err tied 0; LOOP exits only on comp=1.
// STRUCTURE
//  fact_pkg: typedef enum logic [1:0] {IDLE, INIT, LOOP, DONE} fact_state_t; localparams N_W, RES_W defaults.
//  No sub-module; FSM, capture registers and watchdog are inline. Top-level pairs fact_ctrl with datapath.
// TESTING (bench = fact_ctrl + datapath, self-checking)
//  1 n_in=3, start 1 cycle, res_ready=1 -> res_valid at T+6, res_data=6, res_err=0, busy low next cycle.
//  2 n_in=0 and n_in=7 -> res_data=1 (at T+3) and 5040 (at T+10).
//  3 res_ready=0 for 5 cycles in DONE -> res_valid/res_data stable; start pulses ignored; accept on ready.
//  4 start held high continuously, n_in=2,4 alternating -> back-to-back results 2, 24; each n captured only at IDLE.
//  5 rst=1 during LOOP (n=5) -> next cycle IDLE, busy=0, res_valid=0; subsequent n=4 gives 24.
//  6 FACT_WDOG_EN, comp forced 0 -> after 8 LOOP cycles res_valid=1, res_err=1, res_data=0; undefined -> stays busy.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and default sizes for the factorial controller.
// Imported by fact_ctrl.
package fact_pkg;

   localparam int N_W   = 3;
   localparam int RES_W = 13;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      LOOP,
      DONE
   } fact_state_t;

endpackage

// File: rtl/fact_ctrl.sv
// Factorial datapath sequencer with a valid/ready result port.
// Optional watchdog abort enabled by defining FACT_WDOG_EN.
module fact_ctrl
   import fact_pkg::*;
#(
   parameter int N_W   = fact_pkg::N_W,
   parameter int RES_W = fact_pkg::RES_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_W-1:0]   n_in,
   input  logic             comp,
   input  logic [RES_W-1:0] salida,
   output logic [N_W-1:0]   n,
   output logic             inic,
   output logic             habilita_c,
   output logic             fuente,
   output logic             cargar,
   output logic             busy,
   output logic             res_valid,
   output logic [RES_W-1:0] res_data,
   input  logic             res_ready,
   output logic             res_err
);

   fact_state_t      r_state;
   logic [N_W-1:0]   r_n;
   logic             r_res_valid;
   logic [RES_W-1:0] r_res_data;
   logic             w_abort;

`ifdef FACT_WDOG_EN
   logic [N_W:0]     r_iter;
   logic [N_W:0]     w_iter_nx;
   logic             r_res_err;

   assign w_iter_nx = r_iter + 1'b1;
   // the first time the top bit sets, 2**N_W iterations have run without comp
   assign w_abort   = w_iter_nx[N_W];
   assign res_err   = r_res_err;

   // iteration watchdog and its error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_iter    <= '0;
         r_res_err <= 1'b0;
      end else begin
         unique case (r_state)
            INIT: r_iter <= '0;
            LOOP: begin
               if (!comp) begin
                  r_iter <= w_iter_nx;
                  if (w_abort) r_res_err <= 1'b1;
               end
            end
            DONE: if (res_ready) r_res_err <= 1'b0;
            default: ;
         endcase
      end
   end
`else
   assign w_abort = 1'b0;
   assign res_err = 1'b0;
`endif

   assign n         = r_n;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign busy      = (r_state != IDLE);

   // datapath strobes decoded from state and comparator
   always_comb begin
      inic       = 1'b0;
      habilita_c = 1'b0;
      fuente     = 1'b0;
      cargar     = 1'b0;
      unique case (r_state)
         INIT: begin
            inic       = 1'b1;
            habilita_c = 1'b1;
            fuente     = 1'b1;
            cargar     = 1'b1;
         end
         LOOP: begin
            if (!comp) begin
               habilita_c = 1'b1;
               cargar     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // control FSM with operand capture and registered result port
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_n         <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_n     <= n_in;
                  r_state <= INIT;
               end
            end
            INIT: r_state <= LOOP;
            LOOP: begin
               if (comp) begin
                  r_res_data  <= salida;
                  r_res_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (w_abort) begin
                  r_res_data  <= '0;
                  r_res_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench: fact_ctrl paired with a behavioural factorial datapath.
// Directed requests with hand-computed results and latencies.
module tb_fact_ctrl;

   localparam int N_W   = 3;
   localparam int RES_W = 13;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [N_W-1:0]   n_in;
   logic             comp;
   logic [RES_W-1:0] salida;
   logic [N_W-1:0]   n;
   logic             inic;
   logic             habilita_c;
   logic             fuente;
   logic             cargar;
   logic             busy;
   logic             res_valid;
   logic [RES_W-1:0] res_data;
   logic             res_ready;
   logic             res_err;

   logic [N_W:0]     cuenta;
   logic             comp_kill;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fact_ctrl #(.N_W(N_W), .RES_W(RES_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .n_in       (n_in),
      .comp       (comp),
      .salida     (salida),
      .n          (n),
      .inic       (inic),
      .habilita_c (habilita_c),
      .fuente     (fuente),
      .cargar     (cargar),
      .busy       (busy),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .res_err    (res_err)
   );

   // datapath: counter, comparator, multiplier, result register
   assign comp = comp_kill ? 1'b0 : ({1'b0, n} < cuenta);

   always_ff @(posedge clk) begin
      if (rst) begin
         cuenta <= '0;
         salida <= '0;
      end else begin
         if (habilita_c) cuenta <= inic ? 1 : cuenta + 1'b1;
         if (cargar)
            salida <= fuente ? 1 : RES_W'(salida * cuenta);
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // start for one cycle, count cycles until res_valid
   task automatic req(input int nv, output int lat);
      start = 1'b1;
      n_in  = N_W'(nv);
      step();
      start = 1'b0;
      lat   = 1;
      while (!res_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   int lat;
   int hold;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      n_in      = '0;
      res_ready = 1'b0;
      comp_kill = 1'b0;
      step();
      step();
      rst = 1'b0;

      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_data", res_data, 0);
      check("rst_n", n, 0);
      check("rst_err", res_err, 0);
      check("rst_strobes",
            {inic, habilita_c, fuente, cargar}, 0);

      // n=3 with consumer ready
      res_ready = 1'b1;
      req(3, lat);
      check("n3_lat", lat, 6);
      check("n3_data", res_data, 6);
      check("n3_err", res_err, 0);
      step();
      check("n3_busy_after", busy, 0);
      check("n3_valid_after", res_valid, 0);

      // boundaries n=0 and n=7
      req(0, lat);
      check("n0_lat", lat, 3);
      check("n0_data", res_data, 1);
      step();
      req(7, lat);
      check("n7_lat", lat, 10);
      check("n7_data", res_data, 5040);
      step();

      // consumer stalls in DONE, start pulses ignored
      res_ready = 1'b0;
      req(5, lat);
      check("n5_lat", lat, 8);
      check("n5_data", res_data, 120);
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         n_in  = 3'd1;
         step();
         check("stall_valid", res_valid, 1);
         check("stall_data", res_data, 120);
         check("stall_n", n, 5);
      end
      start     = 1'b0;
      res_ready = 1'b1;
      step();
      check("stall_release_valid", res_valid, 0);
      check("stall_release_busy", busy, 0);
      step();
      check("stall_no_queue", busy, 0);

      // start held high: back-to-back 2 then 4
      start = 1'b1;
      n_in  = 3'd2;
      step();
      n_in = 3'd4;
      check("b2b_n_first", n, 2);
      check("b2b_inic", {inic, habilita_c, fuente, cargar}, 15);
      lat = 1;
      while (!res_valid && lat < 40) begin
         step();
         lat++;
      end
      check("b2b_lat1", lat, 5);
      check("b2b_data1", res_data, 2);
      step();
      check("b2b_idle", busy, 0);
      hold = 0;
      step();
      start = 1'b0;
      hold  = 1;
      check("b2b_n_second", n, 4);
      while (!res_valid && hold < 40) begin
         step();
         hold++;
      end
      check("b2b_lat2", hold, 7);
      check("b2b_data2", res_data, 24);
      step();

      // reset during LOOP aborts
      start = 1'b1;
      n_in  = 3'd5;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("mid_busy", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_n", n, 0);
      req(4, lat);
      check("post_rst_lat", lat, 7);
      check("post_rst_data", res_data, 24);
      step();

      // comparator stuck low
      comp_kill = 1'b1;
`ifdef FACT_WDOG_EN
      req(3, lat);
      check("wdog_lat", lat, 10);
      check("wdog_err", res_err, 1);
      check("wdog_data", res_data, 0);
      step();
      check("wdog_err_clr", res_err, 0);
      check("wdog_valid_clr", res_valid, 0);
`else
      req(3, lat);
      check("nowdog_valid", res_valid, 0);
      check("nowdog_busy", busy, 1);
      check("nowdog_err", res_err, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
`endif
      comp_kill = 1'b0;
      req(1, lat);
      check("final_lat", lat, 4);
      check("final_data", res_data, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
